// File: rtl/cond_unit_e.sv
// Execute-stage condition unit: evaluates CondE against the NZCV register and gates Execute controls.
// Optional perf counters (ExecCnt/SquashCnt/CntClr) are built only when COND_PERF_CNT_EN is defined.
module cond_unit_e (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  CondE,
   input  logic [1:0]  FlagWriteE,
   input  logic [3:0]  ALUFlags,
   input  logic        PCSrcE,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        BranchE,
   output logic        PCSrcGE,
   output logic        RegWriteGE,
   output logic        MemWriteGE,
   output logic        BranchTakenE,
   output logic [3:0]  FlagsE,
   output logic        CondExE
`ifdef COND_PERF_CNT_EN
   ,
   input  logic        CntClr,
   output logic [31:0] ExecCnt,
   output logic [31:0] SquashCnt
`endif
);

   typedef enum logic [3:0] {
      C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
      C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
   } cond_t;

   logic n_flag, z_flag, c_flag, v_flag;
   cond_t cond;

   assign {n_flag, z_flag, c_flag, v_flag} = FlagsE;
   assign cond = cond_t'(CondE);

   // Evaluated from the registered flags, so an update made this cycle is seen by the next instruction.
   always_comb begin
      // NOTE: default assignment first so no path through the case can infer a latch.
      CondExE = 1'b0;
      case (cond)
         C_EQ: CondExE = z_flag;
         C_NE: CondExE = ~z_flag;
         C_CS: CondExE = c_flag;
         C_CC: CondExE = ~c_flag;
         C_MI: CondExE = n_flag;
         C_PL: CondExE = ~n_flag;
         C_VS: CondExE = v_flag;
         C_VC: CondExE = ~v_flag;
         C_HI: CondExE = c_flag & ~z_flag;
         C_LS: CondExE = ~c_flag | z_flag;
         C_GE: CondExE = (n_flag == v_flag);
         C_LT: CondExE = (n_flag != v_flag);
         C_GT: CondExE = ~z_flag & (n_flag == v_flag);
         C_LE: CondExE = z_flag | (n_flag != v_flag);
         C_AL: CondExE = 1'b1;
         C_NV: CondExE = 1'b0;
      endcase
   end

   assign PCSrcGE      = PCSrcE    & CondExE;
   assign RegWriteGE   = RegWriteE & CondExE;
   assign MemWriteGE   = MemWriteE & CondExE;
   assign BranchTakenE = BranchE   & CondExE;

   // NZ and CV are written independently; a squashed or bubble instruction leaves both pairs intact.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
      if (reset) begin
         FlagsE <= 4'b0000;
      end else begin
         if (FlagWriteE[1] & CondExE) FlagsE[3:2] <= ALUFlags[3:2];
         if (FlagWriteE[0] & CondExE) FlagsE[1:0] <= ALUFlags[1:0];
      end
   end

`ifdef COND_PERF_CNT_EN
   logic valid_e;

   assign valid_e = PCSrcE | RegWriteE | MemWriteE | BranchE | (|FlagWriteE);

   // Saturating counters; a clear wins over any increment in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || CntClr) begin
         ExecCnt   <= 32'd0;
         SquashCnt <= 32'd0;
      end else if (valid_e) begin
         if (CondExE && (ExecCnt != 32'hFFFF_FFFF))
            ExecCnt <= ExecCnt + 32'd1;
         if (!CondExE && (SquashCnt != 32'hFFFF_FFFF))
            SquashCnt <= SquashCnt + 32'd1;
      end
   end
`else
   // Counter ports and logic are absent in this build.
`endif

endmodule

// File: tb/tb_cond_unit_e.sv
// Scoreboard bench for cond_unit_e: expected outputs are queued when stimulus is driven and popped at sampling.
// Define COND_PERF_CNT_EN to also exercise the performance counters.
module tb_cond_unit_e;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  CondE;
   logic [1:0]  FlagWriteE;
   logic [3:0]  ALUFlags;
   logic        PCSrcE, RegWriteE, MemWriteE, BranchE;
   logic        PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE;
   logic [3:0]  FlagsE;
   logic        CondExE;
   logic        CntClr;
`ifdef COND_PERF_CNT_EN
   logic [31:0] ExecCnt, SquashCnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic        cond_ex;
      logic        pc_g, rw_g, mw_g, br_g;
      logic [3:0]  flags;
      logic [31:0] ec, sc;
   } exp_t;

   exp_t sb[$];

   // Reference state
   logic [3:0]  m_flags;
   logic [31:0] m_ec, m_sc;

   always #5 clk = ~clk;

   cond_unit_e dut (
      .clk          (clk),
      .reset        (reset),
      .CondE        (CondE),
      .FlagWriteE   (FlagWriteE),
      .ALUFlags     (ALUFlags),
      .PCSrcE       (PCSrcE),
      .RegWriteE    (RegWriteE),
      .MemWriteE    (MemWriteE),
      .BranchE      (BranchE),
      .PCSrcGE      (PCSrcGE),
      .RegWriteGE   (RegWriteGE),
      .MemWriteGE   (MemWriteGE),
      .BranchTakenE (BranchTakenE),
      .FlagsE       (FlagsE),
      .CondExE      (CondExE)
`ifdef COND_PERF_CNT_EN
      ,
      .CntClr       (CntClr),
      .ExecCnt      (ExecCnt),
      .SquashCnt    (SquashCnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Condition as base predicate on CondE[3:1], inverted by CondE[0]; 1111 never executes.
   function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'b1111) return 1'b0;
      return base ^ c[0];
   endfunction

   // Called at a negedge: drives one cycle, checks outputs, advances the model over the posedge.
   task automatic step(input string tag, input logic [3:0] cond, input logic [1:0] fw,
                       input logic [3:0] alu, input logic pc, input logic rw, input logic mw,
                       input logic br, input logic rst, input logic clr);
      exp_t e, got_e;
      logic ce, valid;
      reset = rst; CondE = cond; FlagWriteE = fw; ALUFlags = alu;
      PCSrcE = pc; RegWriteE = rw; MemWriteE = mw; BranchE = br; CntClr = clr;
      ce = model_cond(cond, m_flags);
      e.cond_ex = ce;
      e.pc_g = pc & ce; e.rw_g = rw & ce; e.mw_g = mw & ce; e.br_g = br & ce;
      e.flags = m_flags; e.ec = m_ec; e.sc = m_sc;
      sb.push_back(e);
      #1;
      got_e = sb.pop_front();
      check({tag, ".condex"}, {31'd0, CondExE},      {31'd0, got_e.cond_ex});
      check({tag, ".pcsrc"},  {31'd0, PCSrcGE},      {31'd0, got_e.pc_g});
      check({tag, ".regwr"},  {31'd0, RegWriteGE},   {31'd0, got_e.rw_g});
      check({tag, ".memwr"},  {31'd0, MemWriteGE},   {31'd0, got_e.mw_g});
      check({tag, ".brtk"},   {31'd0, BranchTakenE}, {31'd0, got_e.br_g});
      check({tag, ".flags"},  {28'd0, FlagsE},       {28'd0, got_e.flags});
`ifdef COND_PERF_CNT_EN
      check({tag, ".exec"},   ExecCnt,   got_e.ec);
      check({tag, ".squash"}, SquashCnt, got_e.sc);
`endif
      valid = pc | rw | mw | br | (|fw);
      @(posedge clk);
      if (rst) begin
         m_flags = 4'b0000;
      end else begin
         if (fw[1] & ce) m_flags[3:2] = alu[3:2];
         if (fw[0] & ce) m_flags[1:0] = alu[1:0];
      end
      if (rst || clr) begin
         m_ec = 0; m_sc = 0;
      end else if (valid) begin
         if (ce && m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
         if (!ce && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end
      @(negedge clk);
   endtask

   // Load flags through an always-executing write of both pairs.
   task automatic set_flags(input logic [3:0] f);
      step("setf", 4'b1110, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic probe(input string tag, input logic [3:0] cond, input logic exp_ce);
      step(tag, cond, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check({tag, ".const"}, {31'd0, model_cond(cond, m_flags)}, {31'd0, exp_ce});
   endtask

   initial begin
      reset = 1'b1; CondE = '0; FlagWriteE = '0; ALUFlags = '0;
      PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; BranchE = 0; CntClr = 0;
      m_flags = 4'b0000; m_ec = 0; m_sc = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset held: flags 0000, EQ evaluates true? No: Z=0 so EQ is false.
      step("rst_hold", 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("rst_flags", {28'd0, FlagsE}, 32'd0);

      // After reset: EQ squashes RegWrite, AL passes it
      step("eq_after_rst", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("al_after_rst", 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Set Z, then EQ branch is taken next cycle
      step("setz", 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("eq_branch", 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("eq_branch_flags", {28'd0, FlagsE}, 32'h4);

      // NZ-only write keeps C,V
      set_flags(4'b0110);
      step("nz_only", 4'b1110, 2'b10, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("nz_only_chk", 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("nz_only_flags", {28'd0, FlagsE}, 32'hA);

      // Squashed flag write leaves flags alone
      set_flags(4'b0000);
      step("sq_write", 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("sq_write_chk", 4'b1111, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("sq_write_flags", {28'd0, FlagsE}, 32'h0);

      // Signed / unsigned comparisons
      set_flags(4'b1001);
      probe("ge_1001", 4'b1010, 1'b1);
      probe("lt_1001", 4'b1011, 1'b0);
      probe("gt_1001", 4'b1100, 1'b1);
      probe("le_1001", 4'b1101, 1'b0);
      set_flags(4'b1000);
      probe("ge_1000", 4'b1010, 1'b0);
      probe("lt_1000", 4'b1011, 1'b1);
      probe("le_1000", 4'b1101, 1'b1);
      set_flags(4'b0100);
      probe("ls_0100", 4'b1001, 1'b1);
      probe("hi_0100", 4'b1000, 1'b0);

      // Mid-stream reset beats a simultaneous flag write
      step("rst_prio", 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step("rst_prio_chk", 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_prio_flags", {28'd0, FlagsE}, 32'h0);

      // Random mix
      for (int i = 0; i < 60; i++) begin
         step("rand", 4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0), 1'b0);
      end

`ifdef COND_PERF_CNT_EN
      step("clr", 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         step("exec", 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step("squash", 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++)
         step("bubble", 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("cnt_exec5", ExecCnt, 32'd5);
      check("cnt_squash3", SquashCnt, 32'd3);
      step("clr_exec", 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("clr_exec_ec", ExecCnt, 32'd0);
      check("clr_exec_sc", SquashCnt, 32'd0);
      force dut.ExecCnt = 32'hFFFF_FFFF;
      #1;
      release dut.ExecCnt;
      m_ec = 32'hFFFF_FFFF;
      step("sat", 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("sat_hold", ExecCnt, 32'hFFFF_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cond_unit_e.md
COND_UNIT_E -- requirements
Module: cond_unit_e

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port CondE, input, 4 bits: condition field of the instruction in Execute.
REQ-004 SHALL have port FlagWriteE, input, 2 bits: bit1 requests an N,Z update; bit0 requests a C,V update.
REQ-005 SHALL have port ALUFlags, input, 4 bits: ALU result flags {N,Z,C,V} for the instruction in Execute.
REQ-006 SHALL have ports PCSrcE, RegWriteE, MemWriteE and BranchE, each input, 1 bit: ungated Execute controls.
REQ-007 SHALL have ports PCSrcGE, RegWriteGE, MemWriteGE and BranchTakenE, each output, 1 bit: controls gated by the condition.
REQ-008 SHALL have port FlagsE, output, 4 bits: current architectural {N,Z,C,V} register.
REQ-009 SHALL have port CondExE, output, 1 bit: the condition evaluation result.

Function
REQ-010 SHALL evaluate CondExE combinationally from CondE and the current FlagsE register (pre-update value): 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0 (reserved, never executes).
REQ-011 SHALL drive each gated output as the AND of CondExE with its input (PCSrcGE=PCSrcE&CondExE; RegWriteGE, MemWriteGE and BranchTakenE likewise), with zero latency.
REQ-012 SHALL update FlagsE[3:2] from ALUFlags[3:2] on the rising edge only when FlagWriteE[1]&CondExE=1.
REQ-013 SHALL update FlagsE[1:0] from ALUFlags[1:0] on the rising edge only when FlagWriteE[0]&CondExE=1.
REQ-014 SHALL leave each flag pair unchanged when its qualified write is 0, so that a bubble (all controls 0) never modifies flags.
REQ-015 SHALL make an updated flag value visible to the instruction in Execute in the following cycle, which requires no forwarding path.
REQ-016 SHALL treat an instruction as valid when any of PCSrcE, RegWriteE, MemWriteE, BranchE or FlagWriteE is nonzero.

Reset
REQ-017 SHALL clear FlagsE to 4'b0000 when reset is sampled high; with reset held, CondExE follows the REQ-010 table for flags 0000.
REQ-018 SHALL give reset priority over any flag write in the same cycle.
REQ-019 SHALL apply reset asserted mid-stream on the next edge, discarding that cycle's flag update.

Configuration
REQ-020 SHALL include, when macro COND_PERF_CNT_EN is defined, the following ports: input CntClr (1 bit); outputs ExecCnt (32 bits) and SquashCnt (32 bits).
REQ-021 SHALL, with COND_PERF_CNT_EN defined, increment ExecCnt on each valid instruction with CondExE=1 and SquashCnt on each valid instruction with CondExE=0.
REQ-022 SHALL saturate each counter at 32'hFFFFFFFF.
REQ-023 SHALL clear both counters on reset or when CntClr=1; a clear SHALL win over a simultaneous increment.
REQ-024 SHALL, without COND_PERF_CNT_EN, omit the counter ports and logic entirely, with all other behaviour identical.

Verification
REQ-025 Bench SHALL cover: after reset, CondE=0000 with RegWriteE=1 -> FlagsE=0000, CondExE=0, RegWriteGE=0; CondE=1110 -> RegWriteGE=1.
REQ-026 Bench SHALL cover: FlagWriteE=11, CondE=1110, ALUFlags=0100 -> next cycle FlagsE=0100; CondE=0000 with BranchE=1 and PCSrcE=1 -> BranchTakenE=1, PCSrcGE=1.
REQ-027 Bench SHALL cover: FlagsE=0110, FlagWriteE=10, CondE=1110, ALUFlags=1001 -> next cycle FlagsE=1010, with C,V retained.
REQ-028 Bench SHALL cover: FlagsE=0000, CondE=0000, FlagWriteE=11, ALUFlags=1111 -> CondExE=0 and FlagsE stays 0000.
REQ-029 Bench SHALL cover: FlagsE=1001 -> GE=1, LT=0, GT=1, LE=0; FlagsE=1000 -> GE=0, LT=1, LE=1; FlagsE=0100 -> LS=1, HI=0.
REQ-030 Bench SHALL cover (COND_PERF_CNT_EN): 5 executed, 3 squashed and 2 bubble cycles -> ExecCnt=5, SquashCnt=3; CntClr together with an executed instruction -> both counters 0; ExecCnt preset at 32'hFFFFFFFF plus one executed instruction -> stays 32'hFFFFFFFF.
